// File: rtl/simt_scheduler.sv
// Per-core SIMT control FSM: sequences each instruction through the pipeline
// phases and serialises divergent threads by always running the lowest outstanding PC.
module simt_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          start_i,
  input  logic [TC_BITS-1:0]                            thread_count_i,
  input  logic                                          dec_ret_i,
  input  logic [2:0]                                    fetcher_state_i,
  input  logic [THREADS_PER_BLOCK-1:0][1:0]             lsu_state_i,
  input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]     next_pc_i,
  output logic [PC_BITS-1:0]                            current_pc_o,
  output logic [THREADS_PER_BLOCK-1:0]                  active_mask_o,
  output logic [2:0]                                    core_state_o,
  output logic                                          complete_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_e;

  localparam logic [2:0] FETCHED = 3'b010;

  state_e                                       state_q, state_d;
  logic [PC_BITS-1:0]                           current_pc_q, current_pc_d;
  logic [THREADS_PER_BLOCK-1:0]                 active_mask_q, active_mask_d;
  logic                                         complete_q, complete_d;

  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]    thread_pc_q;
  logic [THREADS_PER_BLOCK-1:0]                 done_q;

  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]    cand_pc;
  logic [THREADS_PER_BLOCK-1:0]                 cand_ok;
  logic [THREADS_PER_BLOCK-1:0]                 sel_mask;
  logic [THREADS_PER_BLOCK-1:0]                 lane_busy;
  logic [THREADS_PER_BLOCK-1:0]                 lane_en;
  logic [PC_BITS-1:0]                           min_pc;
  logic                                         any_cand;
  logic                                         launch;
  logic                                         in_update;

  assign launch    = (state_q == S_IDLE) && start_i && (thread_count_i != '0);
  assign in_update = (state_q == S_UPDATE);

  for (genvar gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_lane
    logic ret_lane;

    // Counts above the lane count simply enable every lane.
    assign lane_en[gi]   = 32'(thread_count_i) > 32'(gi);
    assign ret_lane      = active_mask_q[gi] & dec_ret_i;
    assign cand_pc[gi]   = (active_mask_q[gi] && !dec_ret_i) ? next_pc_i[gi] : thread_pc_q[gi];
    assign cand_ok[gi]   = ~done_q[gi] & ~ret_lane;
    assign sel_mask[gi]  = cand_ok[gi] && (cand_pc[gi] == min_pc);
    assign lane_busy[gi] = active_mask_q[gi] &&
                           ((lsu_state_i[gi] == 2'b01) || (lsu_state_i[gi] == 2'b10));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        thread_pc_q[gi] <= '0;
        done_q[gi]      <= 1'b1;
      end else if (launch) begin
        thread_pc_q[gi] <= '0;
        done_q[gi]      <= ~lane_en[gi];
      end else if (in_update && active_mask_q[gi]) begin
        if (dec_ret_i) done_q[gi] <= 1'b1;
        else           thread_pc_q[gi] <= next_pc_i[gi];
      end
    end
  end

  // Lowest PC among lanes still live after this update; ties reconverge.
  always_comb begin
    min_pc   = '1;
    any_cand = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (cand_ok[i] && (!any_cand || (cand_pc[i] < min_pc))) begin
        min_pc   = cand_pc[i];
        any_cand = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    current_pc_d  = current_pc_q;
    active_mask_d = active_mask_q;
    complete_d    = complete_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (thread_count_i == '0) begin
            state_d    = S_DONE;
            complete_d = 1'b1;
          end else begin
            state_d       = S_FETCH;
            current_pc_d  = '0;
            active_mask_d = lane_en;
          end
        end
      end
      S_FETCH:   if (fetcher_state_i == FETCHED) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if (!(|lane_busy)) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        if (any_cand) begin
          state_d       = S_FETCH;
          current_pc_d  = min_pc;
          active_mask_d = sel_mask;
        end else begin
          state_d       = S_DONE;
          complete_d    = 1'b1;
          active_mask_d = '0;
        end
      end
      S_DONE:    state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      current_pc_q  <= '0;
      active_mask_q <= '0;
      complete_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      current_pc_q  <= current_pc_d;
      active_mask_q <= active_mask_d;
      complete_q    <= complete_d;
    end
  end

  assign current_pc_o  = current_pc_q;
  assign active_mask_o = active_mask_q;
  assign core_state_o  = state_q;
  assign complete_o    = complete_q;

endmodule

// File: tb/tb_simt_scheduler.sv
// Directed bench for simt_scheduler: uniform flow, divergence/reconvergence,
// partial retire, LSU gating, thread_count edges and asynchronous reset.
module tb_simt_scheduler;

  localparam int T = 4;
  localparam int P = 8;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [2:0] S_DONE    = 3'b111;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [2:0]             thread_count;
  logic                   dec_ret;
  logic [2:0]             fetcher_state;
  logic [T-1:0][1:0]      lsu_state;
  logic [T-1:0][P-1:0]    next_pc;
  logic [P-1:0]           current_pc;
  logic [T-1:0]           active_mask;
  logic [2:0]             core_state;
  logic                   complete;

  int checks = 0;
  int errors = 0;

  simt_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(P)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .thread_count_i (thread_count),
    .dec_ret_i      (dec_ret),
    .fetcher_state_i(fetcher_state),
    .lsu_state_i    (lsu_state),
    .next_pc_i      (next_pc),
    .current_pc_o   (current_pc),
    .active_mask_o  (active_mask),
    .core_state_o   (core_state),
    .complete_o     (complete)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; dec_ret = 1'b0; fetcher_state = 3'b000;
    lsu_state = '0; next_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic launch(input logic [2:0] tc);
    start = 1'b1;
    thread_count = tc;
    tick();
    start = 1'b0;
  endtask

  // One instruction from FETCH entry to the cycle after UPDATE. Lane 1 is busy
  // for w1 WAIT cycles; lane 3 reports WAITING throughout when hold3 is set.
  task automatic step(input logic [T-1:0][P-1:0] npc, input logic ret, input int fdly,
                      input int w1, input logic hold3, input string tag);
    fetcher_state = 3'b000;
    for (int k = 0; k < fdly; k++) tick();
    check({tag, ":fetch"}, 32'(core_state), 32'(S_FETCH));
    fetcher_state = 3'b010;
    tick();
    fetcher_state = 3'b000;
    check({tag, ":decode"}, 32'(core_state), 32'(S_DECODE));
    tick();
    check({tag, ":request"}, 32'(core_state), 32'(S_REQUEST));
    lsu_state[1] = (w1 > 0) ? 2'b10 : 2'b00;
    lsu_state[3] = hold3 ? 2'b10 : 2'b00;
    tick();
    for (int k = 0; k < w1; k++) begin
      check({tag, ":wait_busy"}, 32'(core_state), 32'(S_WAIT));
      tick();
    end
    lsu_state[1] = 2'b00;
    check({tag, ":wait_last"}, 32'(core_state), 32'(S_WAIT));
    tick();
    check({tag, ":execute"}, 32'(core_state), 32'(S_EXECUTE));
    next_pc = npc;
    dec_ret = ret;
    tick();
    check({tag, ":update"}, 32'(core_state), 32'(S_UPDATE));
    tick();
    dec_ret = 1'b0;
    next_pc = '0;
    lsu_state = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; thread_count = 3'd0; dec_ret = 1'b0;
    fetcher_state = 3'b000; lsu_state = '0; next_pc = '0;
    #2;
    check("rst_state", 32'(core_state), 32'(S_IDLE));
    check("rst_pc", 32'(current_pc), 32'd0);
    check("rst_mask", 32'(active_mask), 32'd0);
    check("rst_complete", 32'(complete), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Uniform flow, no branch
    launch(3'd4);
    check("A_start_state", 32'(core_state), 32'(S_FETCH));
    check("A_start_mask", 32'(active_mask), 32'hF);
    check("A_start_pc", 32'(current_pc), 32'd0);
    step({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 2, 0, 1'b0, "A0");
    check("A_pc1", 32'(current_pc), 32'd1);
    check("A_mask1", 32'(active_mask), 32'hF);
    step({8'd2, 8'd2, 8'd2, 8'd2}, 1'b0, 0, 0, 1'b0, "A1");
    check("A_pc2", 32'(current_pc), 32'd2);
    check("A_mask2", 32'(active_mask), 32'hF);
    check("A_notdone", 32'(complete), 32'd0);
    step({8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 1, 0, 1'b0, "A2");
    check("A_done_state", 32'(core_state), 32'(S_DONE));
    check("A_complete", 32'(complete), 32'd1);
    check("A_done_mask", 32'(active_mask), 32'd0);
    check("A_done_pc", 32'(current_pc), 32'd2);
    launch(3'd4);
    check("A_start_in_done", 32'(core_state), 32'(S_DONE));
    check("A_pc_hold", 32'(current_pc), 32'd2);

    // Divergence at PC 3 and reconvergence at PC 9
    do_reset();
    launch(3'd4);
    step({8'd3, 8'd3, 8'd3, 8'd3}, 1'b0, 0, 0, 1'b0, "B0");
    check("B_pc3", 32'(current_pc), 32'd3);
    step({8'd9, 8'd5, 8'd9, 8'd5}, 1'b0, 0, 0, 1'b0, "B1");
    check("B_div_pc", 32'(current_pc), 32'd5);
    check("B_div_mask", 32'(active_mask), 32'h5);
    step({8'd0, 8'd9, 8'd0, 8'd9}, 1'b0, 0, 0, 1'b0, "B2");
    check("B_reconv_pc", 32'(current_pc), 32'd9);
    check("B_reconv_mask", 32'(active_mask), 32'hF);
    step('0, 1'b1, 0, 0, 1'b0, "B3");
    check("B_complete", 32'(complete), 32'd1);

    // Partial retire with LSU gating on the PC-4 instruction
    do_reset();
    launch(3'd4);
    step({8'd7, 8'd7, 8'd4, 8'd4}, 1'b0, 0, 0, 1'b0, "C0");
    check("C_pc4", 32'(current_pc), 32'd4);
    check("C_mask4", 32'(active_mask), 32'h3);
    step('0, 1'b1, 0, 5, 1'b1, "C1");
    check("C_pc7", 32'(current_pc), 32'd7);
    check("C_mask7", 32'(active_mask), 32'hC);
    check("C_not_complete", 32'(complete), 32'd0);
    check("C_state7", 32'(core_state), 32'(S_FETCH));
    step('0, 1'b1, 0, 0, 1'b0, "C2");
    check("C_done_state", 32'(core_state), 32'(S_DONE));
    check("C_complete", 32'(complete), 32'd1);

    // thread_count = 0
    do_reset();
    launch(3'd0);
    check("D_state", 32'(core_state), 32'(S_DONE));
    check("D_complete", 32'(complete), 32'd1);
    check("D_mask", 32'(active_mask), 32'd0);

    // thread_count = 2: lanes 2,3 never selected even with lower PCs
    do_reset();
    launch(3'd2);
    check("E_mask", 32'(active_mask), 32'h3);
    step({8'd1, 8'd1, 8'd3, 8'd3}, 1'b0, 0, 0, 1'b0, "E0");
    check("E_pc", 32'(current_pc), 32'd3);
    check("E_mask3", 32'(active_mask), 32'h3);
    step('0, 1'b1, 0, 0, 1'b0, "E1");
    check("E_complete", 32'(complete), 32'd1);

    // thread_count above lane count
    do_reset();
    launch(3'd7);
    check("E_over_mask", 32'(active_mask), 32'hF);

    // Asynchronous reset in the middle of WAIT
    do_reset();
    launch(3'd4);
    step({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 0, 0, 1'b0, "F0");
    check("F_pc1", 32'(current_pc), 32'd1);
    fetcher_state = 3'b010;
    tick();
    fetcher_state = 3'b000;
    tick();
    lsu_state[0] = 2'b10;
    tick();
    check("F_in_wait", 32'(core_state), 32'(S_WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    check("F_async_state", 32'(core_state), 32'(S_IDLE));
    check("F_async_pc", 32'(current_pc), 32'd0);
    check("F_async_mask", 32'(active_mask), 32'd0);
    check("F_async_complete", 32'(complete), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lsu_state = '0;
    launch(3'd4);
    check("F_restart_state", 32'(core_state), 32'(S_FETCH));
    check("F_restart_pc", 32'(current_pc), 32'd0);
    check("F_restart_mask", 32'(active_mask), 32'hF);
    step('0, 1'b1, 0, 0, 1'b0, "F1");
    check("F_complete", 32'(complete), 32'd1);
    check("F_final_pc", 32'(current_pc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
